// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave is the arbiter's view; master is the requesters/memory view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;

    logic                  gpu_req;
    logic                  gpu_we;
    logic [ADDR_WIDTH-1:0] gpu_addr;
    logic [DATA_WIDTH-1:0] gpu_wdata;
    logic [DATA_WIDTH-1:0] gpu_rdata;
    logic                  gpu_ack;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_read_ack;

    logic                  busy;
    logic                  timeout_err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  gpu_req, gpu_we, gpu_addr, gpu_wdata,
        output gpu_rdata, gpu_ack,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_read_ack,
        output busy, timeout_err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output gpu_req, gpu_we, gpu_addr, gpu_wdata,
        input  gpu_rdata, gpu_ack,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_read_ack,
        input  busy, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin CPU/GPU arbiter for a single-port memory.
// Reads that never see mem_read_ack complete with all-ones data.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

    state_t                state, state_d;
    logic                  last, last_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic                  rd, rd_d;
    logic                  wr, wr_d;
    logic [ADDR_WIDTH-1:0] addr, addr_d;
    logic [DATA_WIDTH-1:0] wdata, wdata_d;
    logic                  cack, cack_d;
    logic                  gack, gack_d;
    logic [DATA_WIDTH-1:0] crd, crd_d;
    logic [DATA_WIDTH-1:0] grd, grd_d;
    logic                  terr, terr_d;

    logic                  cpu_el;
    logic                  gpu_el;
    logic                  pick_gpu;
    logic                  we_sel;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdat;

    // A requester whose ack is high this cycle must not be re-granted.
    assign cpu_el   = bus.cpu_req & ~cack;
    assign gpu_el   = bus.gpu_req & ~gack;
    // last = 1 means GPU held the previous grant.
    assign pick_gpu = gpu_el & (~cpu_el | ~last);
    assign we_sel   = pick_gpu ? bus.gpu_we : bus.cpu_we;
    assign done     = bus.mem_read_ack | (cnt == CW'(TIMEOUT - 1));
    assign rdat     = bus.mem_read_ack ? bus.mem_rdata : '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
            rd    <= 1'b0;
            wr    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            cack  <= 1'b0;
            gack  <= 1'b0;
            crd   <= '0;
            grd   <= '0;
            terr  <= 1'b0;
        end else begin
            state <= state_d;
            last  <= last_d;
            cnt   <= cnt_d;
            rd    <= rd_d;
            wr    <= wr_d;
            addr  <= addr_d;
            wdata <= wdata_d;
            cack  <= cack_d;
            gack  <= gack_d;
            crd   <= crd_d;
            grd   <= grd_d;
            terr  <= terr_d;
        end
    end

    always_comb begin
        state_d = state;
        last_d  = last;
        cnt_d   = cnt;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr;
        wdata_d = wdata;
        cack_d  = 1'b0;
        gack_d  = 1'b0;
        crd_d   = crd;
        grd_d   = grd;
        terr_d  = terr;
        unique case (state)
            IDLE: begin
                if (cpu_el | gpu_el) begin
                    state_d = CMD;
                    last_d  = pick_gpu;
                    addr_d  = pick_gpu ? bus.gpu_addr : bus.cpu_addr;
                    wdata_d = pick_gpu ? bus.gpu_wdata : bus.cpu_wdata;
                    wr_d    = we_sel;
                    rd_d    = ~we_sel;
                end
            end
            CMD: begin
                if (wr) begin
                    state_d = IDLE;
                    cack_d  = ~last;
                    gack_d  = last;
                end else begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (done) begin
                    state_d = IDLE;
                    cack_d  = ~last;
                    gack_d  = last;
                    if (!bus.mem_read_ack) terr_d = 1'b1;
                    if (last) grd_d = rdat;
                    else      crd_d = rdat;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_read    = rd;
    assign bus.mem_write   = wr;
    assign bus.mem_addr    = addr;
    assign bus.mem_wdata   = wdata;
    assign bus.cpu_ack     = cack;
    assign bus.gpu_ack     = gack;
    assign bus.cpu_rdata   = crd;
    assign bus.gpu_rdata   = grd;
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = terr;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed vectors plus mixed traffic
// against a behavioural memory and a reference copy of its contents.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    logic suppress;
    logic inject;

    mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(8),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        bit         we;
        logic [7:0] rdata;
    } exp_t;

    exp_t cpu_q[$];
    exp_t gpu_q[$];
    int   ack_log[$];
    int   checks;
    int   errors;
    int   rd_count;
    int   gack_count;

    logic [7:0] mem     [4096] = '{default: 8'h00};
    logic [7:0] ref_mem [4096] = '{default: 8'h00};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Memory: ack and data one cycle after mem_read unless suppressed.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_read_ack <= 1'b0;
            bus.mem_rdata    <= 8'h00;
        end else begin
            bus.mem_read_ack <= (bus.mem_read & ~suppress) | inject;
            if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr];
            if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_read | bus.mem_write)
                chk("rw_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 0);
            if (bus.cpu_ack | bus.gpu_ack)
                chk("single_ack", {31'd0, bus.cpu_ack & bus.gpu_ack}, 0);
            if (bus.mem_read) rd_count++;
            if (bus.cpu_ack) begin
                ack_log.push_back(0);
                if (cpu_q.size() == 0) begin
                    chk("cpu_spurious_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = cpu_q.pop_front();
                    if (!e.we) chk("cpu_rdata", {24'd0, bus.cpu_rdata},
                                   {24'd0, e.rdata});
                end
            end
            if (bus.gpu_ack) begin
                ack_log.push_back(1);
                gack_count++;
                if (gpu_q.size() == 0) begin
                    chk("gpu_spurious_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = gpu_q.pop_front();
                    if (!e.we) chk("gpu_rdata", {24'd0, bus.gpu_rdata},
                                   {24'd0, e.rdata});
                end
            end
        end
    end

    task automatic wait_ack(input bit g, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (g ? bus.gpu_ack : bus.cpu_ack) begin
                got = 1'b1;
                lat = i - 1;
            end
        end
        if (!got) chk(g ? "gpu_ack_wait" : "cpu_ack_wait", 0, 1);
        @(posedge clk);
        #1;
        if (g) bus.gpu_req = 1'b0;
        else   bus.cpu_req = 1'b0;
    endtask

    task automatic do_access(input bit g, input bit we, input logic [11:0] a,
                             input logic [7:0] d, input bit to,
                             output int lat);
        exp_t e;
        e.we    = we;
        e.rdata = to ? 8'hFF : ref_mem[a];
        if (we) ref_mem[a] = d;
        if (g) begin
            gpu_q.push_back(e);
            bus.gpu_we    = we;
            bus.gpu_addr  = a;
            bus.gpu_wdata = d;
            bus.gpu_req   = 1'b1;
        end else begin
            cpu_q.push_back(e);
            bus.cpu_we    = we;
            bus.cpu_addr  = a;
            bus.cpu_wdata = d;
            bus.cpu_req   = 1'b1;
        end
        wait_ack(g, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog");
    end

    int         lat, lc0, lg0;
    int         r0, r1, g0;
    int         mode;
    bit         cw, gw;
    logic [11:0] ca, ga;
    logic [7:0]  cd, gd;
    exp_t        e;

    initial begin
        checks = 0; errors = 0; rd_count = 0; gack_count = 0;
        suppress = 1'b0; inject = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.gpu_req = 0; bus.gpu_we = 0; bus.gpu_addr = 0; bus.gpu_wdata = 0;
        reset = 1'b1;
        #12;
        chk("rst_busy",  {31'd0, bus.busy}, 0);
        chk("rst_read",  {31'd0, bus.mem_read | bus.mem_write}, 0);
        chk("rst_ack",   {31'd0, bus.cpu_ack | bus.gpu_ack}, 0);
        chk("rst_terr",  {31'd0, bus.timeout_err}, 0);
        chk("rst_addr",  {20'd0, bus.mem_addr}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // CPU write 0x200 = A5 with cycle-exact strobe checks
        e.we = 1'b1; e.rdata = 8'h00;
        cpu_q.push_back(e);
        ref_mem[12'h200] = 8'hA5;
        bus.cpu_we = 1'b1; bus.cpu_addr = 12'h200; bus.cpu_wdata = 8'hA5;
        bus.cpu_req = 1'b1;
        @(negedge clk);
        chk("wr_c0_busy", {31'd0, bus.busy}, 0);
        @(negedge clk);
        chk("wr_c1_write", {31'd0, bus.mem_write}, 1);
        chk("wr_c1_read",  {31'd0, bus.mem_read}, 0);
        chk("wr_c1_addr",  {20'd0, bus.mem_addr}, 32'h200);
        chk("wr_c1_wdata", {24'd0, bus.mem_wdata}, 32'hA5);
        chk("wr_c1_ack",   {31'd0, bus.cpu_ack}, 0);
        @(negedge clk);
        chk("wr_c2_ack",   {31'd0, bus.cpu_ack}, 1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        do_access(0, 0, 12'h200, 8'h00, 0, lat);
        chk("rd_latency", lat, 3);

        // GPU font read with req held through its ack cycle
        do_access(1, 1, 12'h050, 8'h3C, 0, lat);
        chk("gpu_wr_latency", lat, 2);
        r0 = rd_count; g0 = gack_count;
        do_access(1, 0, 12'h050, 8'h00, 0, lat);
        repeat (6) @(negedge clk);
        chk("hold_reads", rd_count - r0, 1);
        chk("hold_acks", gack_count - g0, 1);
        @(posedge clk); #1;

        // Read timeout, then a late ack that must be ignored
        suppress = 1'b1;
        do_access(0, 0, 12'h200, 8'h00, 1, lat);
        chk("to_latency", lat, 17);
        chk("to_terr", {31'd0, bus.timeout_err}, 1);
        suppress = 1'b0;
        @(posedge clk); #1;
        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_busy", {31'd0, bus.busy}, 0);
        chk("late_rdata", {24'd0, bus.cpu_rdata}, 32'hFF);
        @(posedge clk); #1;
        do_access(0, 0, 12'h200, 8'h00, 0, lat);
        chk("post_to_latency", lat, 3);
        chk("terr_sticky", {31'd0, bus.timeout_err}, 1);

        // Asynchronous reset while the read sits in WAIT
        suppress = 1'b1;
        bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200; bus.cpu_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {31'd0, bus.busy}, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_busy",  {31'd0, bus.busy}, 0);
        chk("async_addr",  {20'd0, bus.mem_addr}, 0);
        chk("async_terr",  {31'd0, bus.timeout_err}, 0);
        chk("async_rdata", {24'd0, bus.cpu_rdata}, 0);
        chk("async_ack",   {31'd0, bus.cpu_ack}, 0);
        suppress = 1'b0;
        @(posedge clk); #1;
        e.we = 1'b0; e.rdata = ref_mem[12'h200];
        cpu_q.push_back(e);
        reset = 1'b0;
        wait_ack(0, lat);
        chk("after_rst_latency", lat, 3);

        // Fresh reset, then both requesters reading continuously
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        ack_log.delete();
        fork
            begin
                do_access(0, 0, 12'h200, 8'h00, 0, lc0);
                repeat (2) do_access(0, 0, 12'h200, 8'h00, 0, lat);
            end
            begin
                do_access(1, 0, 12'h050, 8'h00, 0, lg0);
                repeat (2) do_access(1, 0, 12'h050, 8'h00, 0, lat);
            end
        join
        chk("tie_cpu_latency", lc0, 3);
        chk("tie_gpu_latency", lg0, 6);
        chk("alt_count", ack_log.size(), 6);
        for (int i = 0; i < ack_log.size() && i < 6; i++)
            chk("alt_order", ack_log[i], i % 2);

        // Mixed traffic, CPU and GPU confined to disjoint address ranges
        for (int k = 0; k < 40; k++) begin
            mode = $urandom_range(0, 2);
            cw = 1'($urandom_range(0, 1));
            gw = 1'($urandom_range(0, 1));
            ca = {9'h000, 3'($urandom_range(0, 7))};
            ga = {9'h100, 3'($urandom_range(0, 7))};
            cd = 8'($urandom_range(0, 255));
            gd = 8'($urandom_range(0, 255));
            if (mode == 0) begin
                do_access(0, cw, ca, cd, 0, lat);
                chk("rand_cpu_latency", lat, cw ? 2 : 3);
            end else if (mode == 1) begin
                do_access(1, gw, ga, gd, 0, lat);
                chk("rand_gpu_latency", lat, gw ? 2 : 3);
            end else begin
                fork
                    do_access(0, cw, ca, cd, 0, r1);
                    do_access(1, gw, ga, gd, 0, lat);
                join
            end
        end

        repeat (4) @(negedge clk);
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("gpu_q_drained", gpu_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
